// File: rtl/kiwinpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kiwinpu_pkg                                                  |
// | Description : Shared constants, loader state encoding and the ReLU and     |
// |               saturation helpers used by the KiwiNPU datapath.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package kiwinpu_pkg;

    localparam logic [7:0]  SPI_READ_CMD    = 8'h03;
    localparam logic [23:0] FLASH_BASE_ADDR = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } loader_state_e;

    // The helpers work on 64-bit signed values so that they are independent of
    // the accumulator width chosen by the instantiating module.
    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        relu = (v < 64'sd0) ? 64'sd0 : v;
    endfunction

    // Clamp v to the signed range of a dw-bit element.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kiwinpu_weight_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kiwinpu_weight_loader                                        |
// | Description : Boots the network parameters from a SPI NOR flash with a     |
// |               single READ (0x03) from address 0, using io0 as a 3-wire     |
// |               half-duplex line, and holds them in a flat byte image.       |
// | Ports       : clk, rst_n                  clock, async active-low reset    |
// |               flash_csb/clk/io0_oe/io0_do flash control and command out    |
// |               flash_io0_di                serial read data                 |
// |               weights_ready               image complete, held to reset    |
// |               o_w1/o_b1/o_w2/o_b2         flat parameter buses             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module kiwinpu_weight_loader
    import kiwinpu_pkg::*;
#(
    parameter int IN_N       = 4,
    parameter int HIDDEN_N   = 4,
    parameter int OUT_N      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  flash_csb,
    output logic                                  flash_clk,
    output logic                                  flash_io0_oe,
    output logic                                  flash_io0_do,
    input  logic                                  flash_io0_di,
    output logic                                  weights_ready,
    output logic [HIDDEN_N*IN_N*DATA_WIDTH-1:0]   o_w1,
    output logic [HIDDEN_N*DATA_WIDTH-1:0]        o_b1,
    output logic [OUT_N*HIDDEN_N*DATA_WIDTH-1:0]  o_w2,
    output logic [OUT_N*DATA_WIDTH-1:0]           o_b2
);

    localparam int c_w1_bits     = HIDDEN_N * IN_N * DATA_WIDTH;
    localparam int c_b1_bits     = HIDDEN_N * DATA_WIDTH;
    localparam int c_w2_bits     = OUT_N * HIDDEN_N * DATA_WIDTH;
    localparam int c_b2_bits     = OUT_N * DATA_WIDTH;
    localparam int c_image_bits  = c_w1_bits + c_b1_bits + c_w2_bits + c_b2_bits;
    localparam int c_total_bytes = c_image_bits / 8;
    localparam int c_bcnt_w      = $clog2(c_total_bytes + 1);
    localparam logic [31:0]         c_header    = {SPI_READ_CMD, FLASH_BASE_ADDR};
    localparam logic [c_bcnt_w-1:0] c_last_byte = c_bcnt_w'(c_total_bytes - 1);

    loader_state_e         r_state, w_state_d;
    logic                  r_csb, w_csb_d;
    logic                  r_sclk, w_sclk_d;
    logic                  r_oe, w_oe_d;
    logic                  r_do, w_do_d;
    logic [31:0]           r_shift, w_shift_d;
    logic [4:0]            r_bit_cnt, w_bit_cnt_d;
    logic [c_bcnt_w-1:0]   r_byte_cnt, w_byte_cnt_d;
    logic [c_image_bits-1:0] r_image, w_image_d;
    logic [7:0]            w_byte;

    always_comb begin
        w_state_d    = r_state;
        w_csb_d      = r_csb;
        w_sclk_d     = r_sclk;
        w_oe_d       = r_oe;
        w_do_d       = r_do;
        w_shift_d    = r_shift;
        w_bit_cnt_d  = r_bit_cnt;
        w_byte_cnt_d = r_byte_cnt;
        w_image_d    = r_image;
        w_byte       = {r_shift[6:0], flash_io0_di};

        case (r_state)
            ST_IDLE: begin
                w_state_d    = ST_CMD;
                w_csb_d      = 1'b0;
                w_sclk_d     = 1'b0;
                w_oe_d       = 1'b1;
                w_do_d       = c_header[31];
                w_shift_d    = c_header;
                w_bit_cnt_d  = 5'd0;
                w_byte_cnt_d = '0;
            end
            ST_CMD, ST_ADDR: begin
                if (!r_sclk) begin
                    w_sclk_d = 1'b1;            // flash samples io0 on this rise
                end else begin
                    w_sclk_d = 1'b0;            // falling edge: present next bit
                    if (r_bit_cnt == 5'd31) begin
                        w_state_d   = ST_DATA;
                        w_oe_d      = 1'b0;     // turn io0 around for read data
                        w_do_d      = 1'b0;
                        w_bit_cnt_d = 5'd0;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 5'd1;
                        w_shift_d   = {r_shift[30:0], 1'b0};
                        w_do_d      = r_shift[30];
                        if (r_bit_cnt == 5'd7) begin
                            w_state_d = ST_ADDR;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (!r_sclk) begin
                    // Rising edge: flash drove this bit on the previous fall.
                    w_sclk_d    = 1'b1;
                    w_shift_d   = {r_shift[30:0], flash_io0_di};
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt[2:0] == 3'd7) begin
                        w_image_d[{r_byte_cnt, 3'b000} +: 8] = w_byte;
                        w_byte_cnt_d = r_byte_cnt + 1'b1;
                        if (r_byte_cnt == c_last_byte) begin
                            // Last bit: no further rise, deselect the flash.
                            w_state_d = ST_DONE;
                            w_csb_d   = 1'b1;
                            w_sclk_d  = 1'b0;
                        end
                    end
                end else begin
                    w_sclk_d = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_csb      <= 1'b1;
            r_sclk     <= 1'b0;
            r_oe       <= 1'b0;
            r_do       <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_image    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_csb      <= w_csb_d;
            r_sclk     <= w_sclk_d;
            r_oe       <= w_oe_d;
            r_do       <= w_do_d;
            r_shift    <= w_shift_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_image    <= w_image_d;
        end
    end

    assign flash_csb     = r_csb;
    assign flash_clk     = r_sclk;
    assign flash_io0_oe  = r_oe;
    assign flash_io0_do  = r_do;
    assign weights_ready = (r_state == ST_DONE);

    // Little-endian element packing in flash equals the flat bit order here.
    assign o_w1 = r_image[0 +: c_w1_bits];
    assign o_b1 = r_image[c_w1_bits +: c_b1_bits];
    assign o_w2 = r_image[c_w1_bits + c_b1_bits +: c_w2_bits];
    assign o_b2 = r_image[c_w1_bits + c_b1_bits + c_w2_bits +: c_b2_bits];

endmodule
`default_nettype wire

// File: rtl/kiwinpu_system.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kiwinpu_system                                               |
// | Description : KiwiNPU top: boots weights from SPI flash, then runs a       |
// |               two-stage pipelined FC network (ReLU hidden, linear out).    |
// | Ports       : clk, rst_n          clock, async active-low reset            |
// |               flash_*             SPI NOR interface (io0 3-wire mode)      |
// |               in_vec              IN_N signed elements, element i at       |
// |                                   [i*DATA_WIDTH +: DATA_WIDTH]             |
// |               out_vec             OUT_N signed elements, same packing      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module kiwinpu_system
    import kiwinpu_pkg::*;
#(
    parameter int IN_N       = 4,
    parameter int HIDDEN_N   = 4,
    parameter int OUT_N      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        flash_csb,
    output logic                        flash_clk,
    output logic                        flash_io0_oe,
    output logic                        flash_io1_oe,
    output logic                        flash_io2_oe,
    output logic                        flash_io3_oe,
    output logic                        flash_io0_do,
    output logic                        flash_io1_do,
    output logic                        flash_io2_do,
    output logic                        flash_io3_do,
    input  logic                        flash_io0_di,
    input  logic                        flash_io1_di,
    input  logic                        flash_io2_di,
    input  logic                        flash_io3_di,
    input  logic [IN_N*DATA_WIDTH-1:0]  in_vec,
    output logic [OUT_N*DATA_WIDTH-1:0] out_vec
);

    logic                                 w_weights_ready;
    logic [HIDDEN_N*IN_N*DATA_WIDTH-1:0]  w_w1;
    logic [HIDDEN_N*DATA_WIDTH-1:0]       w_b1;
    logic [OUT_N*HIDDEN_N*DATA_WIDTH-1:0] w_w2;
    logic [OUT_N*DATA_WIDTH-1:0]          w_b2;

    logic [HIDDEN_N*DATA_WIDTH-1:0]       r_hidden, w_hidden_d;
    logic [OUT_N*DATA_WIDTH-1:0]          r_out, w_out_d;
    logic                                 w_unused;

    // WP# and HOLD# held inactive; io1 is not used in 3-wire mode.
    assign flash_io1_oe = 1'b0;
    assign flash_io2_oe = 1'b1;
    assign flash_io3_oe = 1'b1;
    assign flash_io1_do = 1'b0;
    assign flash_io2_do = 1'b1;
    assign flash_io3_do = 1'b1;
    assign w_unused     = &{1'b0, flash_io1_di, flash_io2_di, flash_io3_di};

    kiwinpu_weight_loader #(
        .IN_N       (IN_N),
        .HIDDEN_N   (HIDDEN_N),
        .OUT_N      (OUT_N),
        .DATA_WIDTH (DATA_WIDTH)
    ) weight_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .flash_csb     (flash_csb),
        .flash_clk     (flash_clk),
        .flash_io0_oe  (flash_io0_oe),
        .flash_io0_do  (flash_io0_do),
        .flash_io0_di  (flash_io0_di),
        .weights_ready (w_weights_ready),
        .o_w1          (w_w1),
        .o_b1          (w_b1),
        .o_w2          (w_w2),
        .o_b2          (w_b2)
    );

    // Stage 1: hidden neurons. Both stages are forced to zero until the image
    // is complete so no partially loaded weights ever reach out_vec.
    for (genvar k = 0; k < HIDDEN_N; k++) begin : g_hidden
        logic signed [ACC_WIDTH-1:0] w_acc;
        always_comb begin
            w_acc = ACC_WIDTH'($signed(w_b1[k*DATA_WIDTH +: DATA_WIDTH]));
            for (int i = 0; i < IN_N; i++) begin
                w_acc = w_acc
                      + ACC_WIDTH'($signed(w_w1[(k*IN_N + i)*DATA_WIDTH +: DATA_WIDTH]))
                      * ACC_WIDTH'($signed(in_vec[i*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
        assign w_hidden_d[k*DATA_WIDTH +: DATA_WIDTH] = w_weights_ready
            ? DATA_WIDTH'(sat(relu(64'(w_acc)), DATA_WIDTH)) : '0;
    end

    // Stage 2: linear output neurons fed from the registered hidden layer.
    for (genvar o = 0; o < OUT_N; o++) begin : g_out
        logic signed [ACC_WIDTH-1:0] w_acc;
        always_comb begin
            w_acc = ACC_WIDTH'($signed(w_b2[o*DATA_WIDTH +: DATA_WIDTH]));
            for (int k = 0; k < HIDDEN_N; k++) begin
                w_acc = w_acc
                      + ACC_WIDTH'($signed(w_w2[(o*HIDDEN_N + k)*DATA_WIDTH +: DATA_WIDTH]))
                      * ACC_WIDTH'($signed(r_hidden[k*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
        assign w_out_d[o*DATA_WIDTH +: DATA_WIDTH] = w_weights_ready
            ? DATA_WIDTH'(sat(64'(w_acc), DATA_WIDTH)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hidden <= '0;
            r_out    <= '0;
        end else begin
            r_hidden <= w_hidden_d;
            r_out    <= w_out_d;
        end
    end

    assign out_vec = r_out;

endmodule
`default_nettype wire

// File: tb/tb_kiwinpu_system.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_kiwinpu_system                                            |
// | Description : Bench for kiwinpu_system with a 3-wire SPI flash model and   |
// |               an integer reference model of the two-layer network.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_kiwinpu_system;

    localparam int NB      = 40;
    localparam int BOOT_TO = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flash_csb, flash_clk;
    logic        io0_oe, io1_oe, io2_oe, io3_oe;
    logic        io0_do, io1_do, io2_do, io3_do;
    logic        io0_di = 1'b0;
    logic [31:0] in_vec = '0;
    logic [31:0] out_vec;

    always #5 clk = ~clk;

    kiwinpu_system dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flash_csb    (flash_csb),
        .flash_clk    (flash_clk),
        .flash_io0_oe (io0_oe),
        .flash_io1_oe (io1_oe),
        .flash_io2_oe (io2_oe),
        .flash_io3_oe (io3_oe),
        .flash_io0_do (io0_do),
        .flash_io1_do (io1_do),
        .flash_io2_do (io2_do),
        .flash_io3_do (io3_do),
        .flash_io0_di (io0_di),
        .flash_io1_di (1'b0),
        .flash_io2_di (1'b1),
        .flash_io3_di (1'b1),
        .in_vec       (in_vec),
        .out_vec      (out_vec)
    );

    logic [7:0] img [NB];
    int checks = 0;
    int errors = 0;

    // ---------------- flash model: READ command, 3-wire on io0 ----------------
    logic        prev_csb  = 1'b1;
    logic        prev_fclk = 1'b0;
    int          hcnt = 0;
    int          dptr = 0;
    int          hdr_events = 0;
    logic [31:0] hdr = '0;
    logic [31:0] last_hdr = '0;

    always begin
        @(flash_csb or flash_clk);
        if (prev_csb && !flash_csb) begin
            hcnt = 0;
            dptr = 0;
            hdr  = '0;
        end else if (!flash_csb && !prev_fclk && flash_clk) begin
            if (hcnt < 32) begin
                hdr  = {hdr[30:0], io0_do};
                hcnt = hcnt + 1;
                if (hcnt == 32) begin
                    last_hdr   = hdr;
                    hdr_events = hdr_events + 1;
                end
            end
        end else if (!flash_csb && prev_fclk && !flash_clk && hcnt == 32 && dptr < NB*8) begin
            io0_di = img[dptr/8][7 - (dptr%8)];
            dptr   = dptr + 1;
        end
        prev_csb  = flash_csb;
        prev_fclk = flash_clk;
    end

    // ---------------- reference model ----------------
    function automatic int sx(input logic [7:0] b);
        sx = int'($signed(b));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x);
        int h [4];
        int acc;
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            acc = sx(img[16 + k]);
            for (int i = 0; i < 4; i++) acc += sx(img[k*4 + i]) * sx(x[i*8 +: 8]);
            h[k] = (acc < 0) ? 0 : ((acc > 127) ? 127 : acc);
        end
        for (int o = 0; o < 4; o++) begin
            acc = sx(img[36 + o]);
            for (int k = 0; k < 4; k++) acc += sx(img[20 + o*4 + k]) * h[k];
            if (acc > 127)  acc = 127;
            if (acc < -128) acc = -128;
            y[o*8 +: 8] = acc[7:0];
        end
        model = y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare and drive ----------------
    // History of the input and ready value seen by each rising edge.
    logic [31:0] p1_in = '0, p2_in = '0;
    logic        p1_rdy = 1'b0, p2_rdy = 1'b0;

    task automatic tick(input logic [31:0] nxt);
        @(negedge clk);
        if (rst_n) begin
            if (p1_rdy && p2_rdy)
                check("pipe_out", out_vec, model(p2_in));
            else if (!p1_rdy)
                check("out_zero_not_ready", out_vec, 32'h0);
        end
        in_vec = nxt;
        p2_in  = p1_in;
        p2_rdy = p1_rdy;
        p1_in  = nxt;
        p1_rdy = rst_n && dut.weight_loader.weights_ready;
    endtask

    task automatic clear_hist();
        p1_rdy = 1'b0;
        p2_rdy = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!dut.weight_loader.weights_ready && n < BOOT_TO) begin
            tick($urandom);
            n++;
        end
        if (n >= BOOT_TO) begin
            checks++;
            errors++;
            $display("FAIL boot_timeout cycles=%0d limit=%0d", n, BOOT_TO);
        end
    endtask

    task automatic check_boot_end(input int exp_events);
        check("boot_header", last_hdr, 32'h03000000);
        check("boot_header_count", 32'(hdr_events), 32'(exp_events));
        check("boot_bits_served", 32'(dptr), 32'(NB*8));
        check("boot_end_pins", {29'b0, flash_csb, flash_clk, io0_oe}, 32'b100);
    endtask

    task automatic boot();
        int ev0;
        ev0   = hdr_events;
        rst_n = 1'b0;
        clear_hist();
        tick($urandom);
        tick($urandom);
        check("reset_pins", {27'b0, flash_csb, flash_clk, io0_oe, io0_do,
              dut.weight_loader.weights_ready}, 32'b10000);
        check("reset_out", out_vec, 32'h0);
        check("const_pins", {26'b0, io1_oe, io2_oe, io3_oe, io1_do, io2_do, io3_do},
              32'b011011);
        rst_n = 1'b1;
        wait_ready();
        check_boot_end(ev0 + 1);
    endtask

    task automatic hold(input logic [31:0] v, input logic [31:0] lit, input string name);
        check({name, "_model"}, model(v), lit);
        tick(v);
        tick(v);
        tick(v);
        check(name, out_vec, lit);
    endtask

    task automatic stream(input int n);
        for (int j = 0; j < n; j++) tick($urandom);
    endtask

    initial begin
        int ev0;

        // All-ones image: h = 4+1 = 5, y = 4*5+1 = 21.
        for (int b = 0; b < NB; b++) img[b] = 8'h01;
        boot();
        hold(32'h01010101, 32'h15151515, "ones");
        stream(20);

        // Identity weights, zero biases: {1,-2,3,-4} -> {1,0,3,0}.
        for (int b = 0; b < NB; b++) img[b] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            img[k*4 + k]      = 8'h01;
            img[20 + k*4 + k] = 8'h01;
        end
        boot();
        hold(32'hFC03FE01, 32'h00030001, "identity_relu");
        stream(40);

        // Positive saturation everywhere.
        for (int b = 0; b < NB; b++) img[b] = 8'h7F;
        boot();
        hold(32'h7F7F7F7F, 32'h7F7F7F7F, "sat_pos");

        // Negative overflow in layer 2: h = 127, y = 4*127*(-128) - 128.
        for (int b = 0; b < NB; b++) img[b] = (b < 20) ? 8'h7F : 8'h80;
        boot();
        hold(32'h7F7F7F7F, 32'h80808080, "sat_neg");
        stream(10);

        // Reset in the middle of the data phase, then a clean reload.
        for (int b = 0; b < NB; b++) img[b] = 8'($urandom_range(0, 255));
        rst_n = 1'b0;
        clear_hist();
        tick($urandom);
        tick($urandom);
        rst_n = 1'b1;
        ev0 = hdr_events;
        stream(300);
        check("midload_busy", {30'b0, flash_csb, dut.weight_loader.weights_ready}, 32'b00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_hist();
        #1;
        check("midload_abort", {29'b0, flash_csb, flash_clk,
              dut.weight_loader.weights_ready}, 32'b100);
        tick($urandom);
        tick($urandom);
        rst_n = 1'b1;
        wait_ready();
        check_boot_end(ev0 + 2);
        stream(80);

        // Fresh random image with a random back-to-back stream.
        for (int b = 0; b < NB; b++) img[b] = 8'($urandom_range(0, 255));
        boot();
        stream(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
